// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and scheduler state encoding.
package fb_pkg;

  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
  localparam int FB_DEPTH  = IMG_W * IMG_H;
  localparam int FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    CAPTURE = 2'd1,
    DISPLAY = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_addr_map.sv
// LCD scan position to frame-buffer read address: offset, single wrap, row multiply.
// Registered, so rd_addr/rd_valid follow lcd_x/lcd_y/lcd_de by one cycle.
module fb_addr_map #(
  parameter int IMG_W    = fb_pkg::IMG_W,
  parameter int IMG_H    = fb_pkg::IMG_H,
  parameter int X_OFFSET = 380,
  parameter int Y_OFFSET = 0
) (
  input  logic                          PixelClk,
  input  logic                          reset,
  input  logic [10:0]                   lcd_x,
  input  logic [9:0]                    lcd_y,
  input  logic                          lcd_de,
  input  logic                          frame_ready,
  output logic [fb_pkg::FB_ADDR_W-1:0]  rd_addr,
  output logic                          rd_valid
);
  import fb_pkg::*;

  logic [10:0]          xs_raw, xs;
  logic [9:0]           ys_raw, ys;
  logic [FB_ADDR_W-1:0] addr_next;

  // Input ranges are bounded so that one conditional subtract always lands in range.
  assign xs_raw    = lcd_x + 11'(X_OFFSET);
  assign ys_raw    = lcd_y + 10'(Y_OFFSET);
  assign xs        = (xs_raw >= 11'(IMG_W)) ? xs_raw - 11'(IMG_W) : xs_raw;
  assign ys        = (ys_raw >= 10'(IMG_H)) ? ys_raw - 10'(IMG_H) : ys_raw;
  assign addr_next = FB_ADDR_W'(ys) * FB_ADDR_W'(IMG_W) + FB_ADDR_W'(xs);

  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_addr  <= addr_next;
      rd_valid <= lcd_de & frame_ready;
    end
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Hands the single 1-bit frame buffer between camera capture and LCD scan-out.
// States: WAIT_VS = wait for camera vsync fall | CAPTURE = writing one frame | DISPLAY = frame held, LCD reads
module frame_buffer_scheduler #(
  parameter int IMG_W       = fb_pkg::IMG_W,
  parameter int IMG_H       = fb_pkg::IMG_H,
  parameter int X_OFFSET    = 380,
  parameter int Y_OFFSET    = 0,
  parameter int AUTO_FRAMES = 0
) (
  input  logic                          PixelClk,
  input  logic                          reset,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [10:0]                   lcd_x,
  input  logic [9:0]                    lcd_y,
  input  logic                          lcd_de,
  input  logic                          lcd_frame_start,
  input  logic                          capture_req,
  output logic                          wr_en,
  output logic [fb_pkg::FB_ADDR_W-1:0]  wr_addr,
  output logic [fb_pkg::FB_ADDR_W-1:0]  rd_addr,
  output logic                          rd_valid,
  output logic                          frame_ready,
  output logic                          short_frame
);
  import fb_pkg::*;

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [15:0]          AUTO_LAST = 16'(AUTO_FRAMES - 1);

  fb_state_t   state;
  logic        vsync_q;
  logic [15:0] frame_cnt;
  logic        vs_fall, vs_rise, auto_hit;

  assign vs_fall  = vsync_q & ~cam_vsync;
  assign vs_rise  = ~vsync_q & cam_vsync;
  assign wr_en    = (state == CAPTURE) & cam_href & ~cam_vsync;
  assign auto_hit = (AUTO_FRAMES != 0) && lcd_frame_start && (frame_cnt == AUTO_LAST);

  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_VS;
      vsync_q     <= 1'b1;
      wr_addr     <= '0;
      frame_cnt   <= '0;
      frame_ready <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      vsync_q     <= cam_vsync;
      short_frame <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_fall) begin
            state   <= CAPTURE;
            wr_addr <= '0;
          end
        end
        CAPTURE: begin
          // Abort has priority; wr_en is already masked by vsync in that cycle.
          if (vs_rise) begin
            short_frame <= 1'b1;
            state       <= WAIT_VS;
          end else if (wr_en) begin
            if (wr_addr == LAST_ADDR) begin
              state       <= DISPLAY;
              wr_addr     <= '0;
              frame_ready <= 1'b1;
              frame_cnt   <= '0;
            end else begin
              wr_addr <= wr_addr + FB_ADDR_W'(1);
            end
          end
        end
        DISPLAY: begin
          if (lcd_frame_start) frame_cnt <= frame_cnt + 16'd1;
          if (capture_req || auto_hit) begin
            state       <= WAIT_VS;
            frame_ready <= 1'b0;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  fb_addr_map #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET)
  ) u_addr_map (
    .PixelClk    (PixelClk),
    .reset       (reset),
    .lcd_x       (lcd_x),
    .lcd_y       (lcd_y),
    .lcd_de      (lcd_de),
    .frame_ready (frame_ready),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid)
  );

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Randomized bench for frame_buffer_scheduler on a reduced frame, plus a full-size address map check.
module tb_frame_buffer_scheduler;
  localparam int W    = 64;
  localparam int H    = 16;
  localparam int XO   = 38;
  localparam int YO   = 5;
  localparam int AUTO = 3;

  logic        PixelClk = 1'b0;
  logic        reset = 1'b0;
  logic        cam_vsync, cam_href, lcd_de, lcd_frame_start, capture_req;
  logic [10:0] lcd_x;
  logic [9:0]  lcd_y;
  logic        wr_en, rd_valid, frame_ready, short_frame;
  logic [18:0] wr_addr, rd_addr;

  logic [10:0] fx;
  logic [9:0]  fy;
  logic        fde, fready, f_valid;
  logic [18:0] f_addr;

  always #5 PixelClk = ~PixelClk;

  frame_buffer_scheduler #(
    .IMG_W(W), .IMG_H(H), .X_OFFSET(XO), .Y_OFFSET(YO), .AUTO_FRAMES(AUTO)
  ) dut (
    .PixelClk(PixelClk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_de(lcd_de), .lcd_frame_start(lcd_frame_start),
    .capture_req(capture_req), .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .frame_ready(frame_ready), .short_frame(short_frame)
  );

  fb_addr_map #(.IMG_W(640), .IMG_H(480), .X_OFFSET(380), .Y_OFFSET(0)) u_map_full (
    .PixelClk(PixelClk), .reset(reset), .lcd_x(fx), .lcd_y(fy), .lcd_de(fde),
    .frame_ready(fready), .rd_addr(f_addr), .rd_valid(f_valid)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the buffer holds and how far the capture has got.
  bit m_cap, m_have, m_short, m_prev_vs;
  int m_addr, m_shown, m_rd;
  bit m_rdv;
  bit hold_lcd = 1'b0;

  task automatic model_reset();
    m_cap = 0; m_have = 0; m_short = 0; m_prev_vs = 1; m_addr = 0; m_shown = 0;
  endtask

  // One clock: inputs already set by the caller; called at posedge+1, returns at next posedge+1.
  task automatic tick();
    bit vf, vr, we;
    if (!hold_lcd) begin
      lcd_x  = 11'($urandom_range(2*W-1-XO, 0));
      lcd_y  = 10'($urandom_range(2*H-1-YO, 0));
      lcd_de = 1'($urandom_range(1, 0));
    end
    #1;
    vf = m_prev_vs & !cam_vsync;
    vr = !m_prev_vs & cam_vsync;
    we = m_cap & cam_href & !cam_vsync;
    check("wr_en", wr_en, we);
    check("wr_addr", wr_addr, m_addr);
    m_rdv   = lcd_de & m_have;
    m_rd    = ((int'(lcd_x) + XO) % W) + ((int'(lcd_y) + YO) % H) * W;
    m_short = m_cap & vr;
    if (m_cap) begin
      if (vr) m_cap = 0;
      else if (we) begin
        m_addr++;
        if (m_addr == W*H) begin
          m_cap = 0; m_have = 1; m_shown = 0; m_addr = 0;
        end
      end
    end else if (m_have) begin
      if (lcd_frame_start) m_shown++;
      if (capture_req || m_shown == AUTO) m_have = 0;
    end else if (vf) begin
      m_cap = 1; m_addr = 0;
    end
    m_prev_vs = cam_vsync;
    @(posedge PixelClk);
    #1;
    check("frame_ready", frame_ready, m_have);
    check("short_frame", short_frame, m_short);
    check("rd_addr", rd_addr, m_rd);
    check("rd_valid", rd_valid, m_rdv);
    capture_req = 0;
    lcd_frame_start = 0;
  endtask

  task automatic capture_frame(input int abort_after, input int req_at);
    int n = 0;
    cam_href = 0; cam_vsync = 1;
    repeat (3) tick();
    cam_vsync = 0;
    tick();
    for (int ln = 0; ln < H; ln++) begin
      for (int px = 0; px < W; px++) begin
        cam_href = 0;
        for (int g = 0; g < 3 && $urandom_range(3, 0) == 0; g++) tick();
        if (n == abort_after) begin
          cam_vsync = 1; cam_href = 1;
          tick();
          check("abort_short", short_frame, 1);
          check("abort_ready", frame_ready, 0);
          cam_href = 0;
          tick();
          check("abort_short_one_cycle", short_frame, 0);
          return;
        end
        cam_href = 1;
        if (n == req_at) capture_req = 1;
        tick();
        n++;
        if (n == W*H) begin
          check("ready_after_last", frame_ready, 1);
          check("wr_addr_wrap", wr_addr, 0);
        end
      end
      cam_href = 0;
      repeat (2) tick();
    end
    cam_vsync = 1;
    tick();
  endtask

  task automatic display_frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(8, 3)) begin
        cam_vsync = 1'($urandom_range(1, 0));
        cam_href  = 1'($urandom_range(1, 0));
        tick();
      end
      cam_vsync = 1; cam_href = 0;
      lcd_frame_start = 1;
      tick();
    end
  endtask

  initial begin
    cam_vsync = 1; cam_href = 0; lcd_de = 0; lcd_frame_start = 0; capture_req = 0;
    lcd_x = 0; lcd_y = 0;
    fx = 0; fy = 0; fde = 0; fready = 0;
    model_reset();

    // Async reset before any clock edge.
    #2 reset = 1;
    #2;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_short_frame", short_frame, 0);
    repeat (2) @(posedge PixelClk);
    #1 reset = 0;

    capture_req = 1;
    tick();
    check("req_in_wait_ignored", frame_ready, 0);

    capture_frame(-1, -1);
    check("first_frame_ready", frame_ready, 1);

    // Wrap boundary on both axes: 89+38-64=63, 26+5-16=15 -> 15*64+63.
    hold_lcd = 1;
    lcd_x = 11'(2*W-1-XO); lcd_y = 10'(2*H-1-YO); lcd_de = 1;
    tick();
    check("rd_boundary", rd_addr, 1023);
    check("rd_valid_de", rd_valid, 1);
    lcd_de = 0;
    tick();
    check("rd_valid_no_de", rd_valid, 0);
    hold_lcd = 0;

    display_frames(2);
    capture_req = 1;
    tick();
    check("req_drops_ready", frame_ready, 0);

    capture_frame(100, -1);
    check("after_abort_not_ready", frame_ready, 0);
    capture_frame(-1, 500);
    check("frame_after_abort_ready", frame_ready, 1);

    display_frames(3);
    check("auto_drops_ready", frame_ready, 0);
    repeat (5) tick();

    capture_frame(-1, 7);
    check("req_in_capture_ignored", frame_ready, 1);
    display_frames(2);
    capture_req = 1;
    lcd_frame_start = 1;
    tick();
    check("req_and_auto_same_cycle", frame_ready, 0);
    display_frames(2);

    // Async reset in the middle of a capture.
    cam_href = 0; cam_vsync = 1;
    repeat (2) tick();
    cam_vsync = 0;
    tick();
    cam_href = 1;
    for (int i = 0; i < 600 && m_addr < 500; i++) tick();
    check("mid_capture_addr", wr_addr, 500);
    #2 reset = 1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_frame_ready", frame_ready, 0);
    check("mid_rst_short", short_frame, 0);
    model_reset();
    cam_href = 0; cam_vsync = 1;
    repeat (2) @(posedge PixelClk);
    #1 reset = 0;
    repeat (6) tick();
    check("no_ready_after_reset", frame_ready, 0);

    // Full-size mapping, X_OFFSET 380.
    fx = 300; fy = 479; fde = 1; fready = 1;
    @(posedge PixelClk); #1;
    check("full_map_306600", f_addr, 306600);
    check("full_map_valid", f_valid, 1);
    fx = 0; fy = 0; fde = 0;
    @(posedge PixelClk); #1;
    check("full_map_origin", f_addr, 380);
    check("full_map_no_de", f_valid, 0);
    fx = 899; fy = 959; fde = 1; fready = 0;
    @(posedge PixelClk); #1;
    check("full_map_last", f_addr, 307199);
    check("full_map_not_ready", f_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Sequences the single 1-bit 640x480 frame buffer (simple dual-port BRAM) between the camera capture side and the LCD scan-out side. It waits for a camera frame boundary, steers one complete frame of thresholded pixels into the write port, then hands the buffer to the LCD by generating wrapped, offset read addresses. Re-capture happens on request or after a programmable number of LCD frames. It sits between the camera input/thresholder and the BRAM + LCD timing generator, on `PixelClk`.

## Interface
- IMG_W, 640, image width in pixels
- IMG_H, 480, image height in lines
- X_OFFSET, 380, horizontal read offset added to lcd_x before wrap
- Y_OFFSET, 0, vertical read offset added to lcd_y before wrap
- AUTO_FRAMES, 0, LCD frames shown before automatic re-capture; 0 = only on capture_req

Ports (one clock; reset is asynchronous and active-high):
- PixelClk  in  1  pixel clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- cam_vsync  in  1  camera vsync, high = vertical blank
- cam_href  in  1  camera line-valid, high = valid pixel this cycle
- lcd_x  in  11  LCD pixel counter, valid range 0..2*IMG_W-1-X_OFFSET
- lcd_y  in  10  LCD line counter, valid range 0..2*IMG_H-1-Y_OFFSET
- lcd_de  in  1  LCD data enable
- lcd_frame_start  in  1  one-cycle pulse at LCD line 0, pixel 0
- capture_req  in  1  one-cycle pulse requesting a new capture
- wr_en  out  1  BRAM write enable
- wr_addr  out  19  BRAM write address
- rd_addr  out  19  BRAM read address
- rd_valid  out  1  rd_addr is meaningful and a frame is held
- frame_ready  out  1  buffer holds a complete frame (DISPLAY state)
- short_frame  out  1  one-cycle pulse when a capture is aborted

## Operation
- States: WAIT_VS, CAPTURE, DISPLAY. Reset enters WAIT_VS.
- WAIT_VS -> CAPTURE on a cam_vsync falling edge (1 last cycle, 0 this cycle). wr_addr is cleared to 0 on this transition.
- CAPTURE:
  - `wr_en = cam_href & ~cam_vsync` (combinational, aligned with pixel data).
  - wr_addr increments on every write.
  - A write at address IMG_W*IMG_H-1 moves the block to DISPLAY next cycle, with wr_addr = 0.
  - A cam_vsync rising edge before completion aborts the capture: short_frame pulses and the block returns to WAIT_VS.
  - If abort and href coincide, abort wins. Since wr_en is gated by ~cam_vsync, no write happens.
- DISPLAY:
  - wr_en = 0.
  - The frame counter increments on lcd_frame_start.
  - Go to WAIT_VS on capture_req, or when AUTO_FRAMES≠0 and the count reaches AUTO_FRAMES. If both occur in the same cycle, a single transition happens.
  - The frame counter clears on entry to DISPLAY.
- capture_req is ignored in WAIT_VS and CAPTURE.
- Read mapping:
  - xs = lcd_x+X_OFFSET; subtract IMG_W once if xs ≥ IMG_W.
  - ys = lcd_y+Y_OFFSET; subtract IMG_H once if ys ≥ IMG_H.
  - rd_addr = ys*IMG_W + xs.
  - No % operator. Use a single conditional subtract; the input ranges guarantee one subtraction suffices.
- Width rules: xs 11 bits, ys 10 bits, product computed in 19 bits. Address max 307199 fits 19 bits.
- rd_valid = lcd_de & frame_ready, registered alongside rd_addr.
- Outside DISPLAY, rd_addr still tracks the mapping but rd_valid = 0. The LCD side blanks on ~rd_valid.

## Timing
- Reset values: wr_en 0, wr_addr 0, rd_addr 0, rd_valid 0, frame_ready 0, short_frame 0, state WAIT_VS, frame counter 0.
- cam_vsync previous-value register resets to 1, so a vsync held low from reset is not treated as an edge.
- rd_addr and rd_valid: 1-cycle latency from lcd_x/lcd_y/lcd_de. BRAM dout is valid 2 cycles after lcd_x, so the LCD path delays DE by 2.
- frame_ready rises the cycle after the final write. It falls the cycle after capture_req or the auto trigger.
- short_frame: exactly one cycle, registered, asserted the cycle after the aborting vsync edge.
- Reset mid-CAPTURE: immediate return to reset values. A partial frame in the BRAM is never flagged ready.

## Structure
- Package fb_pkg: IMG_W, IMG_H, FB_DEPTH = 307200, FB_ADDR_W = 19, and the state enum fb_state_t {WAIT_VS, CAPTURE, DISPLAY}.
- One sub-module, fb_addr_map: offset + wrap + multiply, registered, 1-cycle latency, with parameters X_OFFSET/Y_OFFSET.

## Test plan
- Reset, then a vsync falling edge, then 480 lines of 640 href cycles -> exactly 307200 wr_en pulses with addresses 0..307199. frame_ready rises the cycle after the write to 307199.
- cam_vsync rises after 1000 writes -> short_frame pulses once, state returns to WAIT_VS, frame_ready stays 0, and the next full frame completes normally.
- DISPLAY with lcd_x = 300, lcd_y = 479, X_OFFSET = 380 -> rd_addr = 479*640+40 = 306600 one cycle later, with rd_valid = lcd_de.
- AUTO_FRAMES = 3 -> after the third lcd_frame_start pulse, frame_ready falls and the block waits for a vsync fall. capture_req during CAPTURE has no effect.
- cam_href high in the same cycle as cam_vsync rising in CAPTURE -> wr_en 0, abort taken.
- Async reset asserted mid-CAPTURE at wr_addr 5000 -> all outputs return to reset values without a clock edge. No frame_ready.
